// File: rtl/tow_bot_if.sv
// tow_bot_if: game-side signals of the tug-of-war bot.
// The master drives the time base and round control, and the slave drives the button.
interface tow_bot_if;
   logic       slowen;
   logic       leds_on;
   logic       clr;
   logic       pb;
   logic       armed;
   logic [8:0] delay;
   logic       false_start;

   modport master (
      output slowen, leds_on, clr,
      input  pb, armed, delay, false_start
   );

   modport slave (
      input  slowen, leds_on, clr,
      output pb, armed, delay, false_start
   );
endinterface

// File: rtl/tow_bot.sv
// tow_bot: automated tug-of-war opponent pressing after a random delay.
// Define TOW_BOT_FALSESTART_EN to let the bot foul while armed.
module tow_bot #(
   parameter int unsigned BASE_DLY  = 8,
   parameter int unsigned RAND_BITS = 4,
   parameter int unsigned PRESS_LEN = 4,
   parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
   input logic       clk,
   input logic       rst,
   tow_bot_if.slave  bus
);
   typedef enum logic [2:0] {
      IDLE, ARMED, WAIT, PRESS, DONE
   } state_t;

   localparam int unsigned RMASK_I = (1 << RAND_BITS) - 1;
   localparam logic [7:0]  RMASK   = RMASK_I[7:0];
   localparam logic [8:0]  BASE    = BASE_DLY[8:0];
   localparam logic [8:0]  PLEN    = PRESS_LEN[8:0];

   state_t     state_q;
   logic [7:0] lfsr_q;
   logic [7:0] lfsr_d;
   logic       leds_q;
   logic       go;
   logic [8:0] dcnt_q;
   logic [8:0] pcnt_q;
   logic [8:0] delay_q;
   logic [8:0] delay_d;
   logic       pb_q;
   logic       armed_q;

   // taps x^8+x^6+x^5+x^4+1
   assign lfsr_d  = {lfsr_q[6:0],
                     lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   assign go      = bus.leds_on & ~leds_q;
   assign delay_d = BASE + {1'b0, lfsr_q & RMASK};

`ifdef TOW_BOT_FALSESTART_EN
   logic fs_q;
   logic foul;
   assign foul = bus.slowen && (lfsr_q[7:2] == 6'b0);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         lfsr_q  <= LFSR_SEED;
         leds_q  <= 1'b0;
         dcnt_q  <= '0;
         pcnt_q  <= '0;
         delay_q <= '0;
         pb_q    <= 1'b0;
         armed_q <= 1'b0;
`ifdef TOW_BOT_FALSESTART_EN
         fs_q    <= 1'b0;
`endif
      end else begin
         lfsr_q <= lfsr_d;
         leds_q <= bus.leds_on;
`ifdef TOW_BOT_FALSESTART_EN
         fs_q   <= 1'b0;
`endif
         if (bus.clr) begin
            state_q <= ARMED;
            pb_q    <= 1'b0;
            armed_q <= 1'b1;
            dcnt_q  <= '0;
            pcnt_q  <= '0;
         end else begin
            unique case (state_q)
               ARMED: begin
                  if (go) begin
                     delay_q <= delay_d;
                     dcnt_q  <= delay_d;
                     state_q <= WAIT;
                  end
`ifdef TOW_BOT_FALSESTART_EN
                  // a foul overrides a coincident go
                  if (foul) begin
                     delay_q <= '0;
                     pcnt_q  <= PLEN;
                     state_q <= PRESS;
                     pb_q    <= 1'b1;
                     armed_q <= 1'b0;
                     fs_q    <= 1'b1;
                  end
`endif
               end
               WAIT: begin
                  if (!bus.leds_on) begin
                     state_q <= DONE;
                     armed_q <= 1'b0;
                  end else if (bus.slowen) begin
                     if (dcnt_q == '0) begin
                        pcnt_q  <= PLEN;
                        state_q <= PRESS;
                        pb_q    <= 1'b1;
                        armed_q <= 1'b0;
                     end else begin
                        dcnt_q <= dcnt_q - 9'd1;
                     end
                  end
               end
               PRESS: begin
                  if (bus.slowen) begin
                     if (pcnt_q <= 9'd1) begin
                        pcnt_q  <= '0;
                        state_q <= DONE;
                        pb_q    <= 1'b0;
                     end else begin
                        pcnt_q <= pcnt_q - 9'd1;
                     end
                  end
               end
               IDLE, DONE: begin
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.pb    = pb_q;
   assign bus.armed = armed_q;
   assign bus.delay = delay_q;
`ifdef TOW_BOT_FALSESTART_EN
   assign bus.false_start = fs_q;
`else
   assign bus.false_start = 1'b0;
`endif
endmodule
